// File: rtl/ov7670_capture.sv
// OV7670 pixel capture: assembles RGB444 byte pairs into 12-bit pixels and
// writes them into a frame buffer, one write per pixel, framed by VSYNC/HREF.
// Optional feature macro: OV7670_CAPTURE_LINE_CHECK_EN adds a per-line
// length check reported on output line_err.
module ov7670_capture #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        href,
  input  logic [7:0]  d,
  output logic [18:0] addr,
  output logic [11:0] dout,
  output logic        we,
  output logic        frame_done,
  output logic        overflow
`ifdef OV7670_CAPTURE_LINE_CHECK_EN
  ,
  output logic        line_err
`endif
);

  localparam logic [18:0] FRAME_SIZE = 19'(H_PIXELS * V_LINES);

  typedef enum logic [1:0] {SYNC, VBLANK, ACTIVE} state_t;

  state_t      state;
  state_t      state_next;
  logic        start_frame;
  logic        end_frame;
  logic        capture;

  logic        vsync_q;
  logic        href_q;
  logic [7:0]  d_q;
  logic        phase;
  logic [3:0]  hi;
  logic [18:0] pix_cnt;

  // Register the camera inputs once; all control logic works from these copies
  always_ff @(posedge pclk) begin
    if (rst) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      d_q     <= 8'd0;
    end else begin
      vsync_q <= vsync;
      href_q  <= href;
      d_q     <= d;
    end
  end

  // Frame state register
  always_ff @(posedge pclk) begin
    if (rst) state <= SYNC;
    else     state <= state_next;
  end

  // Next-state logic and frame boundary strobes
  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    case (state)
      SYNC: begin
        if (vsync_q) state_next = VBLANK;
      end
      VBLANK: begin
        if (!vsync_q) begin
          state_next  = ACTIVE;
          start_frame = 1'b1;
        end
      end
      ACTIVE: begin
        if (vsync_q) begin
          state_next = VBLANK;
          end_frame  = 1'b1;
        end
      end
      default: state_next = SYNC;
    endcase
  end

  // A byte is consumed only while a line is valid and the frame has not ended
  assign capture = (state == ACTIVE) && !vsync_q && href_q;

  // Byte pairing, pixel write, address counting and overflow tracking
  always_ff @(posedge pclk) begin
    if (rst) begin
      addr       <= 19'd0;
      dout       <= 12'd0;
      we         <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      pix_cnt    <= 19'd0;
      phase      <= 1'b0;
      hi         <= 4'd0;
    end else begin
      we         <= 1'b0;
      frame_done <= end_frame;
      if (start_frame) begin
        pix_cnt  <= 19'd0;
        overflow <= 1'b0;
      end
      if (capture) begin
        phase <= ~phase;
        if (!phase) begin
          hi <= d_q[3:0];
        end else if (pix_cnt == FRAME_SIZE) begin
          overflow <= 1'b1;
        end else begin
          dout    <= {hi, d_q};
          addr    <= pix_cnt;
          we      <= 1'b1;
          pix_cnt <= pix_cnt + 19'd1;
        end
      end else begin
        phase <= 1'b0;
      end
    end
  end

`ifdef OV7670_CAPTURE_LINE_CHECK_EN
  localparam logic [15:0] LINE_LEN = 16'(H_PIXELS);

  logic        href_d;
  logic [15:0] line_cnt;

  // Count pixels per line and flag lines of the wrong length or odd byte count
  always_ff @(posedge pclk) begin
    if (rst) begin
      href_d   <= 1'b0;
      line_cnt <= 16'd0;
      line_err <= 1'b0;
    end else begin
      href_d <= href_q;
      if (start_frame) begin
        line_cnt <= 16'd0;
        line_err <= 1'b0;
      end else if ((state == ACTIVE) && href_d && !href_q) begin
        if ((line_cnt != LINE_LEN) || phase) line_err <= 1'b1;
        line_cnt <= 16'd0;
      end else if (capture && phase) begin
        line_cnt <= line_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ov7670_capture.sv
// Self-checking bench for ov7670_capture on a reduced 8x4 frame.
module tb_ov7670_capture;

  localparam int H = 8;
  localparam int V = 4;
  localparam int FRAME = H * V;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        vsync = 1'b0;
  logic        href = 1'b0;
  logic [7:0]  d = 8'd0;
  logic [18:0] addr;
  logic [11:0] dout;
  logic        we;
  logic        frame_done;
  logic        overflow;
`ifdef OV7670_CAPTURE_LINE_CHECK_EN
  logic        line_err;
`endif

  ov7670_capture #(.H_PIXELS(H), .V_LINES(V)) dut (
    .pclk(pclk),
    .rst(rst),
    .vsync(vsync),
    .href(href),
    .d(d),
    .addr(addr),
    .dout(dout),
    .we(we),
    .frame_done(frame_done),
    .overflow(overflow)
`ifdef OV7670_CAPTURE_LINE_CHECK_EN
    ,
    .line_err(line_err)
`endif
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int lines;
    int nbytes;
    bit fixed;
    int exp_writes;
    bit exp_ovf;
    bit exp_lerr;
  } vec_t;

  vec_t        vecs[6];
  logic [30:0] act_q[$];
  logic [30:0] exp_q[$];
  int          m_cnt;
  int          fd_cnt;
  int          tests;
  int          fails;

  // Record every frame-buffer write and every frame_done pulse
  always @(negedge pclk) begin
    if (we === 1'b1) act_q.push_back({addr, dout});
    if (frame_done === 1'b1) fd_cnt++;
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference: pixels are numbered in arrival order; those past the frame size are lost
  task automatic model_pixel(input logic [11:0] px);
    if (m_cnt < FRAME) begin
      exp_q.push_back({19'(m_cnt), px});
      m_cnt++;
    end
  endtask

  task automatic model_reset();
    act_q.delete();
    exp_q.delete();
    m_cnt  = 0;
    fd_cnt = 0;
  endtask

  task automatic send_line(input int nbytes, input bit fixed, input bit model_on);
    logic [7:0] b;
    logic [7:0] prev;
    prev = 8'd0;
    href = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      if (fixed) b = (i % 2 == 0) ? 8'h0A : 8'hBC;
      else       b = 8'($urandom);
      d = b;
      if (model_on && (i % 2 == 1)) model_pixel({prev[3:0], b});
      prev = b;
      tick();
    end
    href = 1'b0;
    d = 8'($urandom);
    repeat (3) tick();
  endtask

  task automatic start_frame();
    vsync = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (3) tick();
  endtask

  task automatic check_writes(input string tag, input int exp_count);
    int n;
    checkOutput({tag, "_count"}, 32'(act_q.size()), 32'(exp_count));
    checkOutput({tag, "_model_count"}, 32'(act_q.size()), 32'(exp_q.size()));
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, "_addr"}, 32'(act_q[i][30:12]), 32'(exp_q[i][30:12]));
      checkOutput({tag, "_dout"}, 32'(act_q[i][11:0]), 32'(exp_q[i][11:0]));
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    model_reset();
    start_frame();
    checkOutput("ovf_clear_at_start", 32'(overflow), 32'd0);
`ifdef OV7670_CAPTURE_LINE_CHECK_EN
    checkOutput("lerr_clear_at_start", 32'(line_err), 32'd0);
`endif
    for (int l = 0; l < v.lines; l++) send_line(v.nbytes, v.fixed, 1'b1);
    vsync = 1'b1;
    repeat (4) tick();
  endtask

  task automatic checkFrame(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    check_writes(tag, v.exp_writes);
    checkOutput({tag, "_overflow"}, 32'(overflow), 32'(v.exp_ovf));
    checkOutput({tag, "_frame_done"}, 32'(fd_cnt), 32'd1);
    if (exp_q.size() > 0) begin
      checkOutput({tag, "_addr_hold"}, 32'(addr), 32'(exp_q[exp_q.size()-1][30:12]));
      checkOutput({tag, "_dout_hold"}, 32'(dout), 32'(exp_q[exp_q.size()-1][11:0]));
    end
    if (v.fixed) checkOutput({tag, "_fixed_dout"}, 32'(dout), 32'h0ABC);
`ifdef OV7670_CAPTURE_LINE_CHECK_EN
    checkOutput({tag, "_line_err"}, 32'(line_err), 32'(v.exp_lerr));
`endif
  endtask

  initial begin
    tests = 0;
    fails = 0;
    vecs[0] = '{lines: 4, nbytes: 16, fixed: 1'b1, exp_writes: 32, exp_ovf: 1'b0, exp_lerr: 1'b0};
    vecs[1] = '{lines: 5, nbytes: 16, fixed: 1'b0, exp_writes: 32, exp_ovf: 1'b1, exp_lerr: 1'b0};
    vecs[2] = '{lines: 4, nbytes: 15, fixed: 1'b0, exp_writes: 28, exp_ovf: 1'b0, exp_lerr: 1'b1};
    vecs[3] = '{lines: 2, nbytes: 16, fixed: 1'b0, exp_writes: 16, exp_ovf: 1'b0, exp_lerr: 1'b0};
    vecs[4] = '{lines: 4, nbytes: 18, fixed: 1'b0, exp_writes: 32, exp_ovf: 1'b1, exp_lerr: 1'b1};
    vecs[5] = '{lines: 3, nbytes: 14, fixed: 1'b0, exp_writes: 21, exp_ovf: 1'b0, exp_lerr: 1'b1};

    // Reset state
    repeat (2) tick();
    checkOutput("rst_addr", 32'(addr), 32'd0);
    checkOutput("rst_dout", 32'(dout), 32'd0);
    checkOutput("rst_we", 32'(we), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    tick();

    // Bytes before any vsync are ignored
    model_reset();
    send_line(16, 1'b0, 1'b0);
    send_line(16, 1'b0, 1'b0);
    checkOutput("sync_no_we", 32'(act_q.size()), 32'd0);
    checkOutput("sync_no_frame_done", 32'(fd_cnt), 32'd0);

    // Reset mid-frame abandons the frame until a fresh vsync sequence
    model_reset();
    start_frame();
    send_line(16, 1'b0, 1'b1);
    send_line(16, 1'b0, 1'b1);
    check_writes("pre_reset", 16);
    model_reset();
    href = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      tick();
    end
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom);
      tick();
    end
    href = 1'b0;
    repeat (3) tick();
    send_line(16, 1'b0, 1'b0);
    checkOutput("post_reset_no_we", 32'(act_q.size()), 32'd0);
    checkOutput("post_reset_no_frame_done", 32'(fd_cnt), 32'd0);
    checkOutput("post_reset_addr", 32'(addr), 32'd0);
    checkOutput("post_reset_dout", 32'(dout), 32'd0);

    // Table-driven frames against the reference model
    for (int k = 0; k < 6; k++) begin
      applyStimulus(vecs[k]);
      checkFrame(vecs[k], k);
    end

    // Write latency: second byte on the pin to we high is two clocks
    model_reset();
    start_frame();
    href = 1'b1;
    d = 8'h05;
    tick();
    d = 8'h67;
    tick();
    href = 1'b0;
    checkOutput("lat_we_early", 32'(we), 32'd0);
    tick();
    checkOutput("lat_we_high", 32'(we), 32'd1);
    checkOutput("lat_addr", 32'(addr), 32'd0);
    checkOutput("lat_dout", 32'(dout), 32'h567);
    tick();
    checkOutput("lat_we_single", 32'(we), 32'd0);
    repeat (3) tick();
    checkOutput("lat_addr_hold", 32'(addr), 32'd0);
    checkOutput("lat_dout_hold", 32'(dout), 32'h567);
    vsync = 1'b1;
    repeat (4) tick();

    // vsync rising inside a line ends the frame and drops the partial pixel
    begin
      logic [7:0] b;
      logic [7:0] prev;
      prev = 8'd0;
      model_reset();
      start_frame();
      href = 1'b1;
      for (int i = 0; i < 10; i++) begin
        b = 8'($urandom);
        d = b;
        if (i == 7) vsync = 1'b1;
        if ((i % 2 == 1) && (i < 7)) model_pixel({prev[3:0], b});
        prev = b;
        tick();
      end
      href = 1'b0;
      repeat (4) tick();
      check_writes("vsync_cut", 3);
      checkOutput("vsync_cut_frame_done", 32'(fd_cnt), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
